// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - arbitrated single-port memory responder for split instruction/data requesters.
// Optional response wait states are enabled by defining MEM_RESP_WAIT_EN.
module mem_responder #(
    parameter int unsigned MEM_WIDTH   = 32,
    parameter int unsigned MEM_SIZE    = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [MEM_WIDTH-1:0] i_rdata,
    output logic                 i_ack,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [MEM_WIDTH-1:0] d_wdata,
    output logic [MEM_WIDTH-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 d_err,
    output logic                 busy
);

    localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        P_INSTR = 1'b0,
        P_DATA  = 1'b1
    } port_t;

    logic [MEM_WIDTH-1:0] mem_q [MEM_SIZE];

    state_t               state_q, state_d;
    port_t                port_q, port_d;
    port_t                last_grant_q, last_grant_d;
    port_t                grant_port;
    logic                 err_q, err_d;
    logic [MEM_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [MEM_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                 mem_we;

    logic                 i_oor, d_oor;
    logic [AW-1:0]        i_idx, d_idx;

    // Range check uses the full 32-bit address so high bits never alias into the array.
    assign i_oor = (i_addr >= MEM_SIZE);
    assign d_oor = (d_addr >= MEM_SIZE);
    assign i_idx = i_addr[AW-1:0];
    assign d_idx = d_addr[AW-1:0];

`ifdef MEM_RESP_WAIT_EN
    localparam int unsigned CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_wait_cycles;
    assign unused_wait_cycles = (WAIT_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_we       = 1'b0;
        grant_port   = P_INSTR;
`ifdef MEM_RESP_WAIT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // Ties go to the port that did not win last time.
                    if (i_req && d_req) begin
                        grant_port = (last_grant_q == P_DATA) ? P_INSTR : P_DATA;
                    end else begin
                        grant_port = d_req ? P_DATA : P_INSTR;
                    end
                    port_d       = grant_port;
                    last_grant_d = grant_port;
                    if (grant_port == P_DATA) begin
                        err_d = d_oor;
                        if (d_oor) begin
                            d_rdata_d = '0;
                        end else if (d_we) begin
                            mem_we    = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            d_rdata_d = mem_q[d_idx];
                        end
                    end else begin
                        err_d     = i_oor;
                        i_rdata_d = i_oor ? '0 : mem_q[i_idx];
                    end
`ifdef MEM_RESP_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
`else
                    state_d = S_RESP;
`endif
                end
            end
            S_WAIT: begin
`ifdef MEM_RESP_WAIT_EN
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = S_RESP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            port_q       <= P_INSTR;
            last_grant_q <= P_INSTR;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifdef MEM_RESP_WAIT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifdef MEM_RESP_WAIT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[d_idx] <= d_wdata;
        end
    end

    assign i_ack   = (state_q == S_RESP) && (port_q == P_INSTR);
    assign d_ack   = (state_q == S_RESP) && (port_q == P_DATA);
    assign i_err   = i_ack && err_q;
    assign d_err   = d_ack && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with a transaction-level memory model.
module tb_mem_responder;

`ifdef MEM_RESP_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack, i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic        busy;

    always #5 clk = ~clk;

    mem_responder #(
        .MEM_WIDTH(32),
        .MEM_SIZE(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the clock edge.
    logic        s_reset = 1'b1;
    logic        s_ireq = 1'b0, s_dreq = 1'b0, s_dwe = 1'b0;
    logic [31:0] s_iaddr = '0, s_daddr = '0, s_dwdata = '0;

    always @(posedge clk) begin
        s_reset  <= reset;
        s_ireq   <= i_req;
        s_dreq   <= d_req;
        s_dwe    <= d_we;
        s_iaddr  <= i_addr;
        s_daddr  <= d_addr;
        s_dwdata <= d_wdata;
    end

    // Model: one outstanding transaction whose ack is due LAT cycles after it is accepted.
    logic [31:0] m_mem [256];
    bit          pend = 1'b0;
    bit          pdata = 1'b0;
    bit          perr = 1'b0;
    int          remain = 0;
    bit          last_data = 1'b0;
    logic [31:0] m_ird = '0, m_drd = '0;
    bit          take_d;
    bit          due;

    always @(negedge clk) begin
        if (!s_reset) begin
            if (pend) begin
                if (remain == 1) pend = 1'b0;
                else remain--;
            end else if (s_ireq || s_dreq) begin
                take_d    = (s_ireq && s_dreq) ? !last_data : s_dreq;
                last_data = take_d;
                pend      = 1'b1;
                pdata     = take_d;
                remain    = LAT;
                if (take_d) begin
                    perr = (s_daddr > 32'd255);
                    if (perr) m_drd = '0;
                    else if (s_dwe) begin
                        m_mem[s_daddr[7:0]] = s_dwdata;
                        m_drd = '0;
                    end else m_drd = m_mem[s_daddr[7:0]];
                end else begin
                    perr  = (s_iaddr > 32'd255);
                    m_ird = perr ? 32'd0 : m_mem[s_iaddr[7:0]];
                end
            end
        end
        if (reset) begin
            pend      = 1'b0;
            last_data = 1'b0;
            m_ird     = '0;
            m_drd     = '0;
        end
        due = pend && (remain == 1);
        chk("m_busy", {31'd0, busy}, {31'd0, pend});
        chk("m_i_ack", {31'd0, i_ack}, {31'd0, due && !pdata});
        chk("m_d_ack", {31'd0, d_ack}, {31'd0, due && pdata});
        chk("m_i_err", {31'd0, i_err}, {31'd0, due && !pdata && perr});
        chk("m_d_err", {31'd0, d_err}, {31'd0, due && pdata && perr});
        chk("m_i_rdata", i_rdata, m_ird);
        chk("m_d_rdata", d_rdata, m_drd);
    end

    // Issue one request, wait for its ack, then let the responder return to idle.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output int bcnt,
                          output logic [31:0] rd, output logic er);
        lat  = 0;
        bcnt = 0;
        rd   = '0;
        er   = 1'b0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (is_d ? d_ack : i_ack) begin
                lat = n;
                rd  = is_d ? d_rdata : i_rdata;
                er  = is_d ? d_err : i_err;
                break;
            end
        end
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        chk("idle_after", {31'd0, busy}, 32'd0);
        #1;
    endtask

    int          lat, bcnt;
    logic [31:0] rd;
    logic        er;
    int          k;
    bit          seq [8];
    int          cyc [8];

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        #1 reset = 1'b0;

        access(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, lat, bcnt, rd, er);
        chk("wr5_lat", lat, LAT);
        chk("wr5_err", {31'd0, er}, 32'd0);
        access(1'b1, 1'b0, 32'd5, 32'h0, lat, bcnt, rd, er);
        chk("rd5_data", rd, 32'hDEADBEEF);

        access(1'b1, 1'b1, 32'd0, 32'hA5A5A5A5, lat, bcnt, rd, er);
        access(1'b0, 1'b0, 32'd256, 32'h0, lat, bcnt, rd, er);
        chk("i256_err", {31'd0, er}, 32'd1);
        chk("i256_rdata", rd, 32'd0);
        access(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, lat, bcnt, rd, er);
        chk("iffff_err", {31'd0, er}, 32'd1);
        chk("iffff_rdata", rd, 32'd0);
        access(1'b1, 1'b1, 32'h00000100, 32'h12345678, lat, bcnt, rd, er);
        chk("dw256_err", {31'd0, er}, 32'd1);
        access(1'b1, 1'b1, 32'h80000000, 32'h87654321, lat, bcnt, rd, er);
        chk("dwhi_err", {31'd0, er}, 32'd1);
        access(1'b0, 1'b0, 32'd0, 32'h0, lat, bcnt, rd, er);
        chk("alias_unchanged", rd, 32'hA5A5A5A5);

        access(1'b1, 1'b1, 32'd255, 32'h0BADF00D, lat, bcnt, rd, er);
        chk("wr255_err", {31'd0, er}, 32'd0);
        access(1'b1, 1'b0, 32'd255, 32'h0, lat, bcnt, rd, er);
        chk("rd255_data", rd, 32'h0BADF00D);

        access(1'b1, 1'b1, 32'd212, 32'h20080005, lat, bcnt, rd, er);
        access(1'b0, 1'b0, 32'd212, 32'h0, lat, bcnt, rd, er);
        chk("i212_data", rd, 32'h20080005);
        chk("i212_lat", lat, LAT);
        chk("i212_busy", bcnt, LAT);

        // Contention straight out of reset: DATA wins the first tie, then alternation.
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'h0000CAFE;
        k = 0;
        for (int c = 1; c <= 4 * (LAT + 1); c++) begin
            @(negedge clk);
            if (i_ack && d_ack) chk("both_acks", 32'd1, 32'd0);
            if ((i_ack || d_ack) && k < 8) begin
                seq[k] = d_ack;
                cyc[k] = c;
                k++;
            end
        end
        #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("arb_count", k, 4);
        for (int j = 0; j < 4 && j < k; j++) begin
            chk("arb_order", {31'd0, seq[j]}, (j % 2 == 0) ? 32'd1 : 32'd0);
            chk("arb_cycle", cyc[j], LAT + j * (LAT + 1));
        end
        @(negedge clk);
        #1;
        access(1'b1, 1'b0, 32'd10, 32'h0, lat, bcnt, rd, er);
        chk("rd10_data", rd, 32'h0000CAFE);

        // Reset right after a write is granted: no ack, write stays committed.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        reset = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", {30'd0, i_ack, d_ack}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_irdata", i_rdata, 32'd0);
        #1 reset = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            chk("mid_rst_noack", {30'd0, i_ack, d_ack}, 32'd0);
        end
        #1;
        access(1'b0, 1'b0, 32'd20, 32'h0, lat, bcnt, rd, er);
        chk("rd20_committed", rd, 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the core's split instruction/data memory interface.
- Owns a single-port word-addressed storage array of MEM_SIZE words.
- Arbitrates between the instruction-fetch requester and the load/store requester, and returns data with a request/acknowledge handshake.
- Sits between the core's fetch/data ports and the on-chip RAM, replacing direct combinational array access so that multi-cycle or contended memory is supported.

Parameters:
- MEM_WIDTH, 32, data word width in bits.
- MEM_SIZE, 256, number of words; valid word addresses are 0..MEM_SIZE-1.
- WAIT_CYCLES, 2, extra response wait states; used only when MEM_RESP_WAIT_EN is defined.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  instruction read request; level, held until i_ack.
- i_addr  input  32  instruction word address.
- i_rdata  output  MEM_WIDTH  instruction read data, valid when i_ack=1.
- i_ack  output  1  one-cycle instruction response strobe.
- i_err  output  1  address out of range; valid with i_ack.
- d_req  input  1  data request; level, held until d_ack.
- d_we  input  1  1=write, 0=read; sampled with d_req.
- d_addr  input  32  data word address.
- d_wdata  input  MEM_WIDTH  write data.
- d_rdata  output  MEM_WIDTH  data read value, valid when d_ack=1.
- d_ack  output  1  one-cycle data response strobe.
- d_err  output  1  address out of range; valid with d_ack.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; i_ack, d_ack, i_err, d_err, busy=0; i_rdata, d_rdata=0; last_grant=INSTR. Array contents are not cleared.
- Reset mid-transaction: the pending response is discarded and no ack is issued. A write already committed on an earlier edge stays committed.
- States:
  - IDLE: requests are sampled here only.
  - WAIT: present only with MEM_RESP_WAIT_EN.
  - RESP: acks asserted.
- IDLE arbitration:
  - Only d_req: grant DATA.
  - Only i_req: grant INSTR.
  - Both: grant the port not equal to last_grant (round-robin). After reset, DATA wins the first tie.
  - Neither: stay in IDLE.
- On the grant edge:
  - Latch port, address, we and wdata. Update last_grant.
  - In-range read: registered array read into the port's rdata register.
  - In-range write: array[d_addr] <= d_wdata; d_rdata <= 0.
  - Out of range (addr >= MEM_SIZE, full 32-bit compare): no array access; rdata <= 0; err flag set.
  - Next state is RESP (or WAIT if that feature is enabled).
- RESP (exactly one cycle): the granted port's ack=1 and its err reflects the range check. The other port's ack/err=0. Next state is IDLE.
- Acks and errs are 0 in every state except RESP. i_rdata and d_rdata hold their last values between responses.
- Latency: request seen in IDLE at cycle N gives ack at cycle N+1. Peak throughput is one access per 2 cycles.
- Requests are ignored outside IDLE. A requester whose req is still high in the cycle after its ack is treated as issuing a new request.
- At most one array access per cycle. Simultaneous i_req and d_req never produce simultaneous acks.
- Reads of a just-written address return the new value, since the write is committed before any later grant.
- Addresses are word indices (PC+1 stepping); the low bits are not byte offsets.

Optional Feature:
- MEM_RESP_WAIT_EN:
  - Defined: after the grant edge, the FSM enters WAIT with a counter loaded to WAIT_CYCLES. The counter decrements each cycle, and RESP is entered when it reaches 0. Latency becomes WAIT_CYCLES+1. WAIT_CYCLES=0 skips WAIT entirely. busy=1 in WAIT. The array access still occurs on the grant edge.
  - Undefined: the WAIT state and counter are absent and latency is fixed at 1.

Test Plan:
- Reset, then write d_we=1 d_addr=5 d_wdata=0xDEADBEEF -> d_ack=1 one cycle later, d_err=0. Then read d_addr=5 -> d_rdata=0xDEADBEEF with d_ack.
- i_req and d_req both high from reset, both held -> ack order DATA, INSTR, DATA, INSTR. Acks at cycles 1,3,5,7 after first sample; never both acks high together.
- i_addr=256 with MEM_SIZE=256 -> i_ack=1, i_err=1, i_rdata=0. i_addr=0xFFFFFFFF gives the same; array unchanged.
- Preloaded array[212]=0x20080005, i_req with i_addr=212 -> i_ack at N+1 with i_rdata=0x20080005, busy=1 for that cycle only.
- Assert reset in the cycle after a grant (before RESP) -> no ack issued; outputs 0; state IDLE. A subsequent read of a write granted in that cycle returns the new value.
- With MEM_RESP_WAIT_EN and WAIT_CYCLES=2, a read request at cycle N -> ack at N+3, busy high N+1..N+3. WAIT_CYCLES=0 -> ack at N+1.
